sram_burst_arbiter: RTL and testbench

SRAM_BURST_ARBITER -- requirements
Module: sram_burst_arbiter

---
 rtl/sram_burst_arbiter_if.sv | 39 +++
 rtl/sram_burst_arbiter.sv | 116 +++++++++++
 tb/tb_sram_burst_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_burst_arbiter_if.sv
// Bus bundle between two burst requesters, the arbiter and a single-port SRAM.
// Ports: none (clk/rst_n stay plain module ports).
//   req_i/we_i/addr_i/len_i/wdata_i : per-requester burst request (slice k = requester k)
//   gnt_o/beat_o/rvalid_o/rdata_o/busy_o : arbiter status back to requesters
//   sram_* : SRAM control/data; sram_dout is driven by the SRAM
// Modports: master = requesters + SRAM side, slave = arbiter side.
interface sram_burst_arbiter_if #(
    parameter int unsigned N_addr = 5,
    parameter int unsigned N_data = 2,
    parameter int unsigned N_cnt  = 4
);
    logic [1:0]          req_i;
    logic [1:0]          we_i;
    logic [2*N_addr-1:0] addr_i;
    logic [2*N_cnt-1:0]  len_i;
    logic [2*N_data-1:0] wdata_i;
    logic [1:0]          gnt_o;
    logic [1:0]          beat_o;
    logic [1:0]          rvalid_o;
    logic [N_data-1:0]   rdata_o;
    logic                busy_o;
    logic                sram_write_en;
    logic                sram_sense_en;
    logic [N_addr-1:0]   sram_addr;
    logic [N_data-1:0]   sram_din;
    logic [N_data-1:0]   sram_dout;

    modport master (
        output req_i, we_i, addr_i, len_i, wdata_i, sram_dout,
        input  gnt_o, beat_o, rvalid_o, rdata_o, busy_o,
               sram_write_en, sram_sense_en, sram_addr, sram_din
    );

    modport slave (
        input  req_i, we_i, addr_i, len_i, wdata_i, sram_dout,
        output gnt_o, beat_o, rvalid_o, rdata_o, busy_o,
               sram_write_en, sram_sense_en, sram_addr, sram_din
    );
endinterface

// File: rtl/sram_burst_arbiter.sv
// Two-requester round-robin burst arbiter driving a single-port SRAM.
// Ports:
//   clk   : clock, all state changes on posedge
//   rst_n : asynchronous active-low reset
//   bus   : sram_burst_arbiter_if.slave (requests in, grants/beats/read data out,
//           SRAM enables/address/write data out, SRAM read data in)
// Sequence per burst: IDLE -> GRANT (1 cycle) -> ACCESS (len+1 beats) -> RECOVER (1 cycle).
module sram_burst_arbiter #(
    parameter int unsigned N_addr = 5,
    parameter int unsigned N_data = 2,
    parameter int unsigned N_cnt  = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    sram_burst_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT, ACCESS, RECOVER} state_t;

    state_t            state;
    logic              owner;
    logic              last_owner;
    logic              we_q;
    logic [N_cnt-1:0]  len_q;
    logic [N_cnt-1:0]  cnt;

    logic              pick_c;
    logic [1:0]        owner_oh_c;
    logic              start_we_c;
    logic [N_addr-1:0] start_addr_c;
    logic [N_cnt-1:0]  start_len_c;
    logic [N_data-1:0] owner_wdata_c;

    // Round-robin pick and per-owner slice selection
    always_comb begin
        pick_c = bus.req_i[1];
        if (bus.req_i == 2'b11) begin
            pick_c = ~last_owner;
        end
        owner_oh_c    = owner ? 2'b10 : 2'b01;
        start_we_c    = owner ? bus.we_i[1] : bus.we_i[0];
        start_addr_c  = owner ? bus.addr_i[2*N_addr-1:N_addr] : bus.addr_i[N_addr-1:0];
        start_len_c   = owner ? bus.len_i[2*N_cnt-1:N_cnt]    : bus.len_i[N_cnt-1:0];
        owner_wdata_c = owner ? bus.wdata_i[2*N_data-1:N_data] : bus.wdata_i[N_data-1:0];
    end

    // Write data passes straight through so the SRAM sees the owner's data of the beat cycle itself
    assign bus.sram_din = (state == ACCESS && we_q) ? owner_wdata_c : '0;

    // Controller FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            owner             <= 1'b0;
            last_owner        <= 1'b1;
            we_q              <= 1'b0;
            len_q             <= '0;
            cnt               <= '0;
            bus.gnt_o         <= '0;
            bus.beat_o        <= '0;
            bus.rvalid_o      <= '0;
            bus.rdata_o       <= '0;
            bus.busy_o        <= 1'b0;
            bus.sram_write_en <= 1'b0;
            bus.sram_sense_en <= 1'b0;
            bus.sram_addr     <= '0;
        end else begin
            bus.gnt_o    <= '0;
            bus.rvalid_o <= '0;
            case (state)
                IDLE: begin
                    if (|bus.req_i) begin
                        owner      <= pick_c;
                        bus.gnt_o  <= pick_c ? 2'b10 : 2'b01;
                        bus.busy_o <= 1'b1;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    we_q              <= start_we_c;
                    len_q             <= start_len_c;
                    last_owner        <= owner;
                    cnt               <= '0;
                    bus.beat_o        <= owner_oh_c;
                    bus.sram_addr     <= start_addr_c;
                    bus.sram_write_en <= start_we_c;
                    bus.sram_sense_en <= ~start_we_c;
                    state             <= ACCESS;
                end
                ACCESS: begin
                    // Read data is captured at the end of its beat; valid shows the cycle after
                    if (!we_q) begin
                        bus.rdata_o  <= bus.sram_dout;
                        bus.rvalid_o <= owner_oh_c;
                    end
                    // Compare against len instead of counting to len+1 so len=all-ones cannot overflow
                    if (cnt == len_q) begin
                        bus.beat_o        <= '0;
                        bus.sram_write_en <= 1'b0;
                        bus.sram_sense_en <= 1'b0;
                        state             <= RECOVER;
                    end else begin
                        cnt           <= cnt + N_cnt'(1);
                        bus.sram_addr <= bus.sram_addr + N_addr'(1);
                    end
                end
                RECOVER: begin
                    bus.busy_o <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_burst_arbiter.sv
// Directed self-checking bench for sram_burst_arbiter with a behavioural SRAM.
module tb_sram_burst_arbiter;
    localparam int unsigned N_addr = 5;
    localparam int unsigned N_data = 2;
    localparam int unsigned N_cnt  = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    sram_burst_arbiter_if #(.N_addr(N_addr), .N_data(N_data), .N_cnt(N_cnt)) bus ();

    sram_burst_arbiter #(.N_addr(N_addr), .N_data(N_data), .N_cnt(N_cnt)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // SRAM model: synchronous write, read data presented while sense is enabled
    logic [N_data-1:0] mem [32];
    always @(posedge clk) begin
        if (bus.sram_write_en) mem[bus.sram_addr] <= bus.sram_din;
    end
    assign bus.sram_dout = bus.sram_sense_en ? mem[bus.sram_addr] : '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_i   = '0;
        bus.we_i    = '0;
        bus.addr_i  = '0;
        bus.len_i   = '0;
        bus.wdata_i = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [19:0] outs;
        rst_n = 1'b0;
        idle_inputs();
        #2;
        outs = {bus.gnt_o, bus.beat_o, bus.rvalid_o, bus.rdata_o, bus.busy_o,
                bus.sram_write_en, bus.sram_sense_en, bus.sram_addr, bus.sram_din, 3'b000};
        n_vec++;
        if (outs !== 20'h0) begin n_err++; $display("FAIL reset_outputs: got %h expected %h", outs, 20'h0); end
        bus.req_i = 2'b11;
        tick();
        tick();
        n_vec++;
        if ({bus.gnt_o, bus.busy_o} !== 3'b000) begin n_err++; $display("FAIL reset_held_no_grant: got %b expected %b", {bus.gnt_o, bus.busy_o}, 3'b000); end
        do_reset();
    endtask

    task automatic test_single_write();
        bus.req_i = 2'b01; bus.we_i = 2'b01; bus.addr_i[4:0] = 5'd3; bus.len_i[3:0] = 4'd2; bus.wdata_i[1:0] = 2'd1;
        tick();
        n_vec++;
        if ({bus.gnt_o, bus.busy_o, bus.beat_o} !== 5'b01_1_00) begin n_err++; $display("FAIL wr_grant: got %b expected %b", {bus.gnt_o, bus.busy_o, bus.beat_o}, 5'b01_1_00); end
        bus.req_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.wdata_i[1:0] = 2'(i + 1);
            if (i == 0) bus.req_i = 2'b10;
            #1;
            n_vec++;
            if ({bus.beat_o, bus.sram_write_en, bus.sram_sense_en, bus.gnt_o} !== 6'b01_1_0_00) begin n_err++; $display("FAIL wr_beat%0d_ctrl: got %b expected %b", i, {bus.beat_o, bus.sram_write_en, bus.sram_sense_en, bus.gnt_o}, 6'b01_1_0_00); end
            n_vec++;
            if (bus.sram_addr !== 5'(3 + i)) begin n_err++; $display("FAIL wr_beat%0d_addr: got %0d expected %0d", i, bus.sram_addr, 3 + i); end
            n_vec++;
            if (bus.sram_din !== 2'(i + 1)) begin n_err++; $display("FAIL wr_beat%0d_din: got %0d expected %0d", i, bus.sram_din, i + 1); end
        end
        tick();
        bus.req_i = 2'b00;
        n_vec++;
        if ({bus.beat_o, bus.sram_write_en, bus.sram_sense_en, bus.busy_o, bus.sram_din, bus.sram_addr} !== {2'b00, 1'b0, 1'b0, 1'b1, 2'd0, 5'd5}) begin
            n_err++; $display("FAIL wr_recover: got %b expected %b", {bus.beat_o, bus.sram_write_en, bus.sram_sense_en, bus.busy_o, bus.sram_din, bus.sram_addr}, {2'b00, 1'b0, 1'b0, 1'b1, 2'd0, 5'd5});
        end
        tick();
        n_vec++;
        if ({bus.busy_o, bus.gnt_o} !== 3'b000) begin n_err++; $display("FAIL wr_idle: got %b expected %b", {bus.busy_o, bus.gnt_o}, 3'b000); end
        tick();
        n_vec++;
        if ({bus.busy_o, bus.gnt_o} !== 3'b000) begin n_err++; $display("FAIL wr_ignored_req_no_grant: got %b expected %b", {bus.busy_o, bus.gnt_o}, 3'b000); end
        idle_inputs();
    endtask

    task automatic test_read_back();
        bus.req_i = 2'b10; bus.we_i = 2'b00; bus.addr_i[9:5] = 5'd3; bus.len_i[7:4] = 4'd2;
        tick();
        n_vec++;
        if (bus.gnt_o !== 2'b10) begin n_err++; $display("FAIL rd_grant: got %b expected %b", bus.gnt_o, 2'b10); end
        bus.req_i = 2'b00;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_vec++;
            if ({bus.beat_o, bus.sram_sense_en, bus.sram_write_en} !== ((c < 3) ? 4'b10_1_0 : 4'b00_0_0)) begin
                n_err++; $display("FAIL rd_cyc%0d_ctrl: got %b expected %b", c, {bus.beat_o, bus.sram_sense_en, bus.sram_write_en}, (c < 3) ? 4'b10_1_0 : 4'b00_0_0);
            end
            if (c < 3) begin
                n_vec++;
                if (bus.sram_addr !== 5'(3 + c)) begin n_err++; $display("FAIL rd_cyc%0d_addr: got %0d expected %0d", c, bus.sram_addr, 3 + c); end
            end
            n_vec++;
            if (bus.rvalid_o !== ((c >= 1) ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL rd_cyc%0d_rvalid: got %b expected %b", c, bus.rvalid_o, (c >= 1) ? 2'b10 : 2'b00); end
            if (c >= 1) begin
                n_vec++;
                if (bus.rdata_o !== 2'(c)) begin n_err++; $display("FAIL rd_cyc%0d_rdata: got %0d expected %0d", c, bus.rdata_o, c); end
            end
        end
        tick();
        n_vec++;
        if ({bus.rvalid_o, bus.busy_o} !== 3'b000) begin n_err++; $display("FAIL rd_idle: got %b expected %b", {bus.rvalid_o, bus.busy_o}, 3'b000); end
        idle_inputs();
    endtask

    task automatic test_contention();
        int         n_gnt;
        logic [1:0] own_oh;
        logic [3:0] order;
        do_reset();
        bus.req_i = 2'b11; bus.we_i = 2'b00;
        bus.addr_i = {5'd20, 5'd10};
        bus.len_i  = '0;
        n_gnt  = 0;
        own_oh = 2'b00;
        order  = '0;
        for (int c = 0; c < 40 && n_gnt < 4; c++) begin
            tick();
            if (bus.gnt_o != 2'b00) begin
                n_vec++;
                if (bus.gnt_o !== 2'b01 && bus.gnt_o !== 2'b10) begin n_err++; $display("FAIL cont_gnt_onehot: got %b expected one bit", bus.gnt_o); end
                order[n_gnt] = bus.gnt_o[1];
                own_oh = bus.gnt_o;
                n_gnt++;
            end
            n_vec++;
            if (((bus.beat_o | bus.rvalid_o) & ~own_oh) !== 2'b00) begin
                n_err++; $display("FAIL cont_nonowner_activity: beat %b rvalid %b owner %b", bus.beat_o, bus.rvalid_o, own_oh);
            end
        end
        n_vec++;
        if (n_gnt != 4) begin n_err++; $display("FAIL cont_grant_count: got %0d expected %0d", n_gnt, 4); end
        n_vec++;
        if (order !== 4'b1010) begin n_err++; $display("FAIL cont_grant_order: got %b expected %b (bit i = owner of grant i)", order, 4'b1010); end
        bus.req_i = 2'b00;
        for (int c = 0; c < 10 && bus.busy_o; c++) tick();
        tick();
        idle_inputs();
    endtask

    task automatic test_wrap();
        bus.req_i = 2'b01; bus.we_i = 2'b01; bus.addr_i[4:0] = 5'd30; bus.len_i[3:0] = 4'd3; bus.wdata_i[1:0] = 2'd2;
        tick();
        n_vec++;
        if (bus.gnt_o !== 2'b01) begin n_err++; $display("FAIL wrap_grant: got %b expected %b", bus.gnt_o, 2'b01); end
        bus.req_i = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if ({bus.beat_o, bus.sram_addr} !== {2'b01, 5'(30 + i)}) begin
                n_err++; $display("FAIL wrap_beat%0d: got beat %b addr %0d expected beat 01 addr %0d", i, bus.beat_o, bus.sram_addr, 5'(30 + i));
            end
        end
        tick();
        tick();
        idle_inputs();
    endtask

    task automatic test_max_len();
        int nb;
        int nr;
        int nbusy;
        bus.req_i = 2'b10; bus.we_i = 2'b00; bus.addr_i[9:5] = 5'd0; bus.len_i[7:4] = 4'd15;
        tick();
        n_vec++;
        if (bus.gnt_o !== 2'b10) begin n_err++; $display("FAIL max_grant: got %b expected %b", bus.gnt_o, 2'b10); end
        bus.req_i = 2'b00;
        nb = 0; nr = 0; nbusy = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (!bus.busy_o) break;
            nbusy++;
            if (bus.beat_o == 2'b10) nb++;
            if (bus.rvalid_o == 2'b10) nr++;
        end
        n_vec++;
        if (nb != 16) begin n_err++; $display("FAIL max_beats: got %0d expected %0d", nb, 16); end
        n_vec++;
        if (nr != 16) begin n_err++; $display("FAIL max_rvalids: got %0d expected %0d", nr, 16); end
        n_vec++;
        if (nbusy != 17) begin n_err++; $display("FAIL max_busy_cycles: got %0d expected %0d", nbusy, 17); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        logic [14:0] outs;
        bus.req_i = 2'b01; bus.we_i = 2'b01; bus.addr_i[4:0] = 5'd8; bus.len_i[3:0] = 4'd5; bus.wdata_i[1:0] = 2'd1;
        tick();
        bus.req_i = 2'b00;
        tick();
        tick();
        tick();
        n_vec++;
        if ({bus.beat_o, bus.sram_addr} !== {2'b01, 5'd10}) begin n_err++; $display("FAIL rst_mid_beat2: got %b expected %b", {bus.beat_o, bus.sram_addr}, {2'b01, 5'd10}); end
        #2;
        rst_n = 1'b0;
        #1;
        outs = {bus.sram_write_en, bus.sram_sense_en, bus.busy_o, bus.beat_o, bus.rvalid_o, bus.gnt_o, bus.sram_addr};
        n_vec++;
        if (outs !== 15'h0) begin n_err++; $display("FAIL rst_mid_async: got %b expected %b", outs, 15'h0); end
        n_vec++;
        if (bus.sram_din !== 2'd0) begin n_err++; $display("FAIL rst_mid_din: got %0d expected %0d", bus.sram_din, 0); end
        bus.req_i = 2'b11;
        tick();
        tick();
        n_vec++;
        if ({bus.beat_o, bus.rvalid_o, bus.busy_o, bus.sram_write_en} !== 6'b0) begin n_err++; $display("FAIL rst_mid_held: got %b expected %b", {bus.beat_o, bus.rvalid_o, bus.busy_o, bus.sram_write_en}, 6'b0); end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (bus.gnt_o !== 2'b01) begin n_err++; $display("FAIL rst_mid_first_grant: got %b expected %b", bus.gnt_o, 2'b01); end
        bus.req_i = 2'b00;
        for (int c = 0; c < 20 && bus.busy_o; c++) tick();
        n_vec++;
        if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_drain: got busy %b expected %b", bus.busy_o, 1'b0); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_back();
        test_contention();
        test_wrap();
        test_max_len();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
